countup_timer: RTL
==================

Name: countup_timer

Overview:
- Decimal elapsed-time stopwatch: counts up from zero in BCD with 1 ms resolution. It is the count-up counterpart of the game's countdown timer.
- Measures how long the player takes to react or reel in, and holds a captured "lap" value for scoring.
- A binary prescaler derives the 1 ms tick from the system clock. A ripple chain of BCD digits accumulates elapsed time.
- Saturates at all-nines and flags overflow.

Parameters:
- Digits, 5, number of BCD digits starting from .001 s. Minimum 2. Default 5 gives xx.xxx s.
- TicksPerMs, 50000, system clock cycles per 1 ms tick (50 MHz clock). Minimum 2.
- PrescaleWidth, 16, width of the prescaler counter. Must satisfy 2^PrescaleWidth >= TicksPerMs.

Ports:
- CLK  input  1  system clock, rising edge. Single clock domain.
- RST  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- Clear  input  1  synchronous clear to zero. Priority over all other inputs.
- Run  input  1  count while high; pause while low.
- Capture  input  1  single-cycle strobe that latches the current elapsed time.
- CurrentValue  output  Digits*4  live elapsed time. 4 bits per BCD digit, most significant digit leftmost.
- CapturedValue  output  Digits*4  value latched by the last accepted Capture.
- CaptureValid  output  1  high once a capture has been taken since the last Clear or reset.
- Overflow  output  1  high while saturated at all nines.
- Running  output  1  high in the RUNNING state.

Behaviour:
- Reset (async, RST=1):
  - State=IDLE.
  - Prescaler=0.
  - CurrentValue=0, CapturedValue=0.
  - CaptureValid=0, Overflow=0, Running=0.
- States: IDLE, RUNNING, PAUSED, SATURATED. All are registered; transitions occur on the CLK rising edge.
- IDLE:
  - Value and prescaler are held at 0.
  - Run=1 -> RUNNING. Otherwise stay in IDLE.
- RUNNING:
  - Prescaler increments every cycle.
  - When the prescaler equals TicksPerMs-1, the next edge does two things: prescaler -> 0, and the BCD chain increments by 1.
  - The first tick therefore lands exactly TicksPerMs cycles after entry to RUNNING.
  - If Run=0 (and no Clear) -> PAUSED. The prescaler keeps its count and no increment happens on that edge.
- PAUSED:
  - Prescaler and value are frozen.
  - Run=1 -> RUNNING. The prescaler resumes from its held count, so partial milliseconds are preserved.
- BCD increment:
  - Digit 0 always increments on a tick.
  - A digit at 9 wraps to 0 and carries into the next digit; all carries resolve in the same cycle.
  - Digits never leave the range 0-9.
- Saturation:
  - A tick while every digit is 9 does not wrap.
  - Value stays at all nines, state -> SATURATED, Overflow=1.
  - In SATURATED the prescaler stops and Run is ignored.
  - Only Clear or reset exits SATURATED.
- Clear:
  - From any state, the next edge sets State=IDLE and zeroes the value, prescaler, CapturedValue, CaptureValid and Overflow.
  - Clear is evaluated before Run, Capture and tick.
- Capture:
  - If Capture=1 and Clear=0, CapturedValue takes CurrentValue as it was before this edge and CaptureValid goes to 1.
  - On a Capture/tick collision the pre-increment value is captured.
  - Capture is accepted in every state, including IDLE (captures 0) and SATURATED.
  - If Capture is held for several cycles, each cycle re-captures.
- Outputs:
  - Running is a Moore decode of State.
  - Overflow is registered.
  - CurrentValue and CapturedValue come directly from registers (no combinational path from the inputs).
- Clear is only a release condition here; reset is async, and a reset mid-count abandons the measurement immediately.

Test Plan:
- Bench config: Digits=3, TicksPerMs=4.
- Scenario 1: release RST, hold Run=1 for 40 cycles -> CurrentValue goes 000, 001 after 4 cycles, then 010 after 40 cycles; Running=1 throughout.
- Scenario 2: Run=1 for 6 cycles, Run=0 for 10 cycles, then Run=1 -> value frozen at 001 while paused. The next tick arrives 2 cycles after resuming, because the prescaler held at 2.
- Scenario 3: run from 000 to 999 (3996 cycles), then 4 more cycles -> value stays 999, Overflow=1, state SATURATED. Toggling Run has no effect; a Clear pulse gives 000, Overflow=0, IDLE.
- Scenario 4: pulse Capture on the same edge that rolls 009 to 010 -> CapturedValue=009, CaptureValid=1, CurrentValue=010.
- Scenario 5: assert Clear and Capture together while running at 057 -> next cycle CurrentValue=000, CapturedValue=000, CaptureValid=0, state IDLE.
- Scenario 6: assert RST asynchronously mid-cycle at value 123 -> all outputs are 0 immediately, before the next CLK edge. After RST is released with Run=1, counting restarts from 000.

Source files
------------

// File: rtl/countup_timer.sv
// BCD elapsed-time stopwatch with a 1 ms prescaler, a lap capture register and saturation at all nines.
// Latency: outputs are registered, and each tick is visible one cycle after it occurs. There is no backpressure: inputs are sampled every cycle.
module countup_timer #(
    parameter int Digits        = 5,
    parameter int TicksPerMs    = 50000,
    parameter int PrescaleWidth = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Clear,
    input  logic                  Run,
    input  logic                  Capture,
    output logic [Digits*4-1:0]   CurrentValue,
    output logic [Digits*4-1:0]   CapturedValue,
    output logic                  CaptureValid,
    output logic                  Overflow,
    output logic                  Running
);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        SATURATED
    } state_t;

    localparam logic [PrescaleWidth-1:0] PresLast = PrescaleWidth'(TicksPerMs - 1);

    state_t                    state_q;
    logic [PrescaleWidth-1:0]  presc_q;
    logic [Digits*4-1:0]       value_q;
    logic [Digits*4-1:0]       capt_q;
    logic                      capt_vld_q;
    logic                      ovf_q;
    logic                      run_q;

    logic [Digits*4-1:0]       value_d;
    logic                      all_nines;

    // Ripple carry through the digits; a carry out of the top digit means the value is all nines.
    always_comb begin
        logic carry;
        carry   = 1'b1;
        value_d = value_q;
        for (int i = 0; i < Digits; i++) begin
            if (carry) begin
                if (value_q[i*4 +: 4] == 4'd9) begin
                    value_d[i*4 +: 4] = 4'd0;
                end else begin
                    value_d[i*4 +: 4] = value_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            value_q    <= '0;
            capt_q     <= '0;
            capt_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            run_q      <= 1'b0;
        end else if (Clear) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            value_q    <= '0;
            capt_q     <= '0;
            capt_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            // Capture takes the value held before this edge, so a coincident tick is not seen.
            if (Capture) begin
                capt_q     <= value_q;
                capt_vld_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (Run) begin
                        state_q <= RUNNING;
                        run_q   <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (!Run) begin
                        state_q <= PAUSED;
                        run_q   <= 1'b0;
                    end else if (presc_q == PresLast) begin
                        presc_q <= '0;
                        if (all_nines) begin
                            state_q <= SATURATED;
                            ovf_q   <= 1'b1;
                            run_q   <= 1'b0;
                        end else begin
                            value_q <= value_d;
                        end
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (Run) begin
                        state_q <= RUNNING;
                        run_q   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign CurrentValue  = value_q;
    assign CapturedValue = capt_q;
    assign CaptureValid  = capt_vld_q;
    assign Overflow      = ovf_q;
    assign Running       = run_q;

endmodule
